// File: rtl/cpu_pkg.sv
// Shared types for the multicycle CPU PC/EPC path: exception FSM states,
// branch condition codes and exception cause codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SAVE  = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        LOAD  = 3'd4
    } exc_state_e;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLE = 2'b10,
        BR_BGT = 2'b11
    } branch_op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_OPCODE = 2'b01,
        CAUSE_OVF    = 2'b10,
        CAUSE_DIV0   = 2'b11
    } exc_cause_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates the branch condition selected by branch_op from the ALU flags.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [1:0] branch_op,
    input  logic       alu_zero,
    input  logic       alu_gt,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (branch_op_e'(branch_op))
            BR_BEQ:  cond = alu_zero;
            BR_BNE:  cond = !alu_zero;
            BR_BLE:  cond = alu_zero || !alu_gt;
            BR_BGT:  cond = alu_gt;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// Architectural PC/EPC registers with branch-qualified commit and the
// exception-entry sequence (save EPC, read vector byte, jump).
//
//  state | meaning
//  IDLE  | normal operation, PC commits from pc_next
//  SAVE  | epc <= pc - 4
//  FETCH | vector byte read issued, latency counter loaded
//  WAIT  | read held until latency counter expires
//  LOAD  | pc <= vector byte, back to IDLE
module pc_update_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_op,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic        exc_start,
    input  logic [1:0]  exc_cause,
    input  logic [7:0]  mem_byte,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        branch_taken,
    output logic        exc_busy,
    output logic        exc_mem_rd,
    output logic [31:0] exc_mem_addr
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);
    localparam bit         LONG_LAT = (MEM_LAT > 1);

    exc_state_e  state_q, state_d;
    exc_cause_e  cause_q, cause_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        busy_q, busy_d;
    logic        rd_q, rd_d;
    logic        cond;
    logic [31:0] vec_addr;

    branch_cond_eval u_cond (
        .branch_op (branch_op),
        .alu_zero  (alu_zero),
        .alu_gt    (alu_gt),
        .cond      (cond)
    );

    assign branch_taken = pc_write_cond && cond && (state_q == IDLE);

    always_comb begin
        vec_addr = 32'd0;
        case (cause_q)
            CAUSE_OPCODE: vec_addr = VEC_OPCODE;
            CAUSE_OVF:    vec_addr = VEC_OVF;
            CAUSE_DIV0:   vec_addr = VEC_DIV0;
            default:      vec_addr = 32'd0;
        endcase
    end

    assign exc_mem_addr = ((state_q == FETCH) || (state_q == WAIT)) ? vec_addr : 32'd0;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        case (state_q)
            IDLE: begin
                // An exception request wins over any PC commit in the same cycle.
                if (exc_start && (exc_cause != CAUSE_NONE)) begin
                    cause_d = exc_cause_e'(exc_cause);
                    state_d = SAVE;
                end else if (pc_write || branch_taken) begin
                    pc_d = pc_next;
                end
            end
            SAVE: begin
                epc_d   = pc_q - 32'd4;
                state_d = FETCH;
            end
            FETCH: begin
                cnt_d   = CNT_INIT;
                state_d = LONG_LAT ? WAIT : LOAD;
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pc_d    = {24'b0, mem_byte};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        rd_d   = (state_d == FETCH) || (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            cnt_q   <= 2'd0;
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign exc_busy   = busy_q;
    assign exc_mem_rd = rd_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, sharing all inputs except the exception request.
module tb_pc_update_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_next;
    logic        pc_write, pc_write_cond;
    logic [1:0]  branch_op;
    logic        alu_zero, alu_gt;
    logic        exc_start1, exc_start3;
    logic [1:0]  exc_cause;
    logic [7:0]  mem_byte;

    logic [31:0] pc1, epc1, addr1, pc3, epc3, addr3;
    logic        bt1, busy1, rd1, bt3, busy3, rd3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_update_unit #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
        .alu_gt(alu_gt), .exc_start(exc_start1), .exc_cause(exc_cause),
        .mem_byte(mem_byte), .pc(pc1), .epc(epc1), .branch_taken(bt1),
        .exc_busy(busy1), .exc_mem_rd(rd1), .exc_mem_addr(addr1)
    );

    pc_update_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
        .alu_gt(alu_gt), .exc_start(exc_start3), .exc_cause(exc_cause),
        .mem_byte(mem_byte), .pc(pc3), .epc(epc3), .branch_taken(bt3),
        .exc_busy(busy3), .exc_mem_rd(rd3), .exc_mem_addr(addr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; pc_next = '0; pc_write = 1'b0; pc_write_cond = 1'b0;
        branch_op = 2'b00; alu_zero = 1'b0; alu_gt = 1'b0;
        exc_start1 = 1'b0; exc_start3 = 1'b0; exc_cause = 2'b00; mem_byte = '0;
        tick(); tick();
        chk("rst_pc", pc1, 32'h0);
        chk("rst_epc", epc1, 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_rd", 32'(rd1), 32'h0);
        chk("rst_addr", addr1, 32'h0);
        reset_n = 1'b1;

        pc_write = 1'b1; pc_next = 32'h40;
        tick();
        pc_write = 1'b0;
        chk("pcw_pc", pc1, 32'h40);
        chk("pcw_epc", epc1, 32'h0);

        pc_write_cond = 1'b1; branch_op = 2'b01; alu_zero = 1'b1; pc_next = 32'h80;
        #1 chk("bne_z1_bt", 32'(bt1), 32'h0);
        tick();
        chk("bne_z1_pc", pc1, 32'h40);
        alu_zero = 1'b0;
        #1 chk("bne_z0_bt", 32'(bt1), 32'h1);
        tick();
        chk("bne_z0_pc", pc1, 32'h80);

        branch_op = 2'b10; alu_zero = 1'b0; alu_gt = 1'b1;
        #1 chk("ble_gt_bt", 32'(bt1), 32'h0);
        alu_gt = 1'b0;
        #1 chk("ble_le_bt", 32'(bt1), 32'h1);
        branch_op = 2'b11; alu_gt = 1'b1;
        #1 chk("bgt_bt", 32'(bt1), 32'h1);
        branch_op = 2'b00; alu_zero = 1'b1;
        #1 chk("beq_bt", 32'(bt1), 32'h1);
        pc_write_cond = 1'b0; alu_zero = 1'b0; alu_gt = 1'b0;

        pc_write = 1'b1; pc_next = 32'h100;
        tick();
        pc_write = 1'b0;
        chk("pc_100", pc1, 32'h100);

        exc_start1 = 1'b1; exc_cause = 2'b10;
        tick();
        exc_start1 = 1'b0;
        chk("ovf_save_busy", 32'(busy1), 32'h1);
        chk("ovf_save_pc", pc1, 32'h100);
        chk("ovf_save_rd", 32'(rd1), 32'h0);
        pc_write_cond = 1'b1; branch_op = 2'b00; alu_zero = 1'b1;
        #1 chk("busy_bt_forced", 32'(bt1), 32'h0);
        tick();
        pc_write_cond = 1'b0; alu_zero = 1'b0;
        chk("ovf_fetch_epc", epc1, 32'hFC);
        chk("ovf_fetch_rd", 32'(rd1), 32'h1);
        chk("ovf_fetch_addr", addr1, 32'd254);
        chk("ovf_fetch_pc", pc1, 32'h100);
        mem_byte = 8'h3C;
        tick();
        chk("ovf_load_rd", 32'(rd1), 32'h0);
        chk("ovf_load_addr", addr1, 32'h0);
        chk("ovf_load_busy", 32'(busy1), 32'h1);
        tick();
        chk("ovf_idle_pc", pc1, 32'h3C);
        chk("ovf_idle_busy", 32'(busy1), 32'h0);

        exc_start1 = 1'b1; exc_cause = 2'b01; pc_write = 1'b1; pc_next = 32'h200;
        tick();
        exc_start1 = 1'b0; pc_write = 1'b0;
        chk("race_save_pc", pc1, 32'h3C);
        chk("race_save_busy", 32'(busy1), 32'h1);
        tick();
        chk("opc_fetch_addr", addr1, 32'd253);
        chk("opc_fetch_epc", epc1, 32'h38);
        mem_byte = 8'h07;
        tick(); tick();
        chk("opc_idle_pc", pc1, 32'h07);

        exc_start1 = 1'b1; exc_cause = 2'b00;
        tick();
        exc_start1 = 1'b0;
        chk("cause00_busy", 32'(busy1), 32'h0);

        // dut3 took the pc_write of 32'h200 while dut1 was entering its exception.
        chk("d3_pc_200", pc3, 32'h200);
        exc_start3 = 1'b1; exc_cause = 2'b11;
        tick();
        exc_start3 = 1'b0;
        chk("d3_save_rd", 32'(rd3), 32'h0);
        pc_write = 1'b1; pc_next = 32'hDEAD;
        tick();
        chk("d3_rd_c1", 32'(rd3), 32'h1);
        chk("d3_addr_c1", addr3, 32'd255);
        chk("d3_epc", epc3, 32'h1FC);
        tick();
        chk("d3_rd_c2", 32'(rd3), 32'h1);
        chk("d3_addr_c2", addr3, 32'd255);
        tick();
        chk("d3_rd_c3", 32'(rd3), 32'h1);
        chk("d3_addr_c3", addr3, 32'd255);
        mem_byte = 8'h5A; pc_write = 1'b0;
        tick();
        chk("d3_load_rd", 32'(rd3), 32'h0);
        chk("d3_load_pc", pc3, 32'h200);
        tick();
        chk("d3_idle_pc", pc3, 32'h5A);
        chk("d3_idle_busy", 32'(busy3), 32'h0);

        pc_write = 1'b1; pc_next = 32'h300;
        tick();
        pc_write = 1'b0;
        exc_start3 = 1'b1; exc_cause = 2'b01;
        tick();
        exc_start3 = 1'b0;
        tick(); tick();
        chk("d3_wait_rd", 32'(rd3), 32'h1);
        chk("d3_wait_epc", epc3, 32'h2FC);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("d3_rst_pc", pc3, 32'h0);
        chk("d3_rst_epc", epc3, 32'h0);
        chk("d3_rst_busy", 32'(busy3), 32'h0);
        chk("d3_rst_rd", 32'(rd3), 32'h0);
        chk("d3_rst_addr", addr3, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
